// File: rtl/merge_pass_scheduler.sv
// Merge-sort pass scheduler: sequences batched multi-channel reads/writes across ping-pong buffers.
// Optional MERGE_PASS_SCHED_PERF_EN adds a 48-bit job_cycles busy-cycle counter output.
module merge_pass_scheduler #(
    parameter int unsigned C_NUM_CHANNELS     = 16,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
    parameter int unsigned C_XFER_SIZE_WIDTH  = 64
) (
    input  logic                                                   aclk,
    input  logic                                                   areset,
    input  logic                                                   start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]                          src_base,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]                          dst_base,
    input  logic [C_XFER_SIZE_WIDTH-1:0]                           total_bytes,
    input  logic [C_XFER_SIZE_WIDTH-1:0]                           init_run_bytes,
    output logic                                                   busy,
    output logic                                                   done,
    output logic [7:0]                                             pass_idx,
    output logic                                                   rd_pass_start,
    output logic                                                   rd_ctrl_start,
    output logic [C_NUM_CHANNELS-1:0][C_M_AXI_ADDR_WIDTH-1:0]      rd_addr_offset,
    output logic [C_XFER_SIZE_WIDTH-1:0]                           rd_xfer_size,
    input  logic                                                   rd_ctrl_done,
    output logic                                                   wr_start,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]                          wr_addr,
    input  logic                                                   wr_batch_done,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]                          result_base
`ifdef MERGE_PASS_SCHED_PERF_EN
    ,
    output logic [47:0]                                            job_cycles
`endif
);

    localparam int unsigned NCH      = C_NUM_CHANNELS;
    localparam int unsigned AW       = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned XW       = C_XFER_SIZE_WIDTH;
    localparam int unsigned LOG2_NCH = $clog2(NCH);
    localparam int unsigned WIDE_W   = XW + LOG2_NCH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PASS_SETUP,
        S_BATCH_ISSUE,
        S_BATCH_LAUNCH,
        S_BATCH_WAIT,
        S_PASS_END,
        S_FINISH
    } state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          src_q, src_d;
    logic [AW-1:0]          dst_q, dst_d;
    logic [XW-1:0]          total_q, total_d;
    logic [XW-1:0]          run_q, run_d;
    logic [XW-1:0]          off_q, off_d;
    logic [7:0]             pass_idx_q, pass_idx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   rd_pass_start_q, rd_pass_start_d;
    logic                   rd_ctrl_start_q, rd_ctrl_start_d;
    logic                   wr_start_q, wr_start_d;
    logic [NCH-1:0][AW-1:0] rd_addr_q, rd_addr_d;
    logic [XW-1:0]          rd_xfer_q, rd_xfer_d;
    logic [AW-1:0]          wr_addr_q, wr_addr_d;
    logic [AW-1:0]          result_base_q, result_base_d;
    logic                   rd_seen_q, rd_seen_d;
    logic                   wr_seen_q, wr_seen_d;
`ifdef MERGE_PASS_SCHED_PERF_EN
    logic [47:0]            job_cycles_q, job_cycles_d;
`endif

    // Widened arithmetic so offset/run growth can be detected and saturated.
    logic [WIDE_W-1:0]      off_sum_w;
    logic [WIDE_W-1:0]      run_shift_w;
    logic [XW-1:0]          run_next;
    logic [XW-1:0]          off_next;
    logic                   start_accept;

    always_comb begin
        off_sum_w    = WIDE_W'(off_q) + (WIDE_W'(run_q) << LOG2_NCH);
        run_shift_w  = WIDE_W'(run_q) << LOG2_NCH;
        run_next     = (run_shift_w[WIDE_W-1:XW] != '0) ? '1 : run_shift_w[XW-1:0];
        off_next     = (off_sum_w[WIDE_W-1:XW] != '0) ? '1 : off_sum_w[XW-1:0];
        start_accept = (state_q == S_IDLE) && start;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d         = state_q;
        src_d           = src_q;
        dst_d           = dst_q;
        total_d         = total_q;
        run_d           = run_q;
        off_d           = off_q;
        pass_idx_d      = pass_idx_q;
        done_d          = 1'b0;
        rd_pass_start_d = 1'b0;
        rd_ctrl_start_d = 1'b0;
        wr_start_d      = 1'b0;
        rd_addr_d       = rd_addr_q;
        rd_xfer_d       = rd_xfer_q;
        wr_addr_d       = wr_addr_q;
        result_base_d   = result_base_q;
        rd_seen_d       = rd_seen_q;
        wr_seen_d       = wr_seen_q;

        case (state_q)
            S_IDLE: begin
                if (start_accept) begin
                    src_d      = src_base;
                    dst_d      = dst_base;
                    total_d    = total_bytes;
                    run_d      = init_run_bytes;
                    off_d      = '0;
                    pass_idx_d = 8'd0;
                    state_d    = S_PASS_SETUP;
                end
            end
            S_PASS_SETUP: begin
                if (run_q >= total_q) begin
                    done_d        = 1'b1;
                    result_base_d = src_q;
                    state_d       = S_FINISH;
                end else begin
                    rd_pass_start_d = 1'b1;
                    state_d         = S_BATCH_ISSUE;
                end
            end
            S_BATCH_ISSUE: begin
                for (int unsigned i = 0; i < NCH; i++) begin
                    rd_addr_d[i] = src_q + AW'(off_q) + AW'(run_q) * AW'(i);
                end
                rd_xfer_d       = run_q;
                wr_addr_d       = dst_q + AW'(off_q);
                rd_ctrl_start_d = 1'b1;
                wr_start_d      = 1'b1;
                state_d         = S_BATCH_LAUNCH;
            end
            S_BATCH_LAUNCH: begin
                rd_seen_d = rd_seen_q | rd_ctrl_done;
                wr_seen_d = wr_seen_q | wr_batch_done;
                state_d   = S_BATCH_WAIT;
            end
            S_BATCH_WAIT: begin
                if (rd_seen_q && wr_seen_q) begin
                    rd_seen_d = 1'b0;
                    wr_seen_d = 1'b0;
                    off_d     = off_next;
                    state_d   = (off_sum_w < WIDE_W'(total_q)) ? S_BATCH_ISSUE : S_PASS_END;
                end else begin
                    rd_seen_d = rd_seen_q | rd_ctrl_done;
                    wr_seen_d = wr_seen_q | wr_batch_done;
                end
            end
            S_PASS_END: begin
                src_d      = dst_q;
                dst_d      = src_q;
                run_d      = run_next;
                off_d      = '0;
                pass_idx_d = pass_idx_q + 8'd1;
                if (run_next >= total_q) begin
                    done_d        = 1'b1;
                    result_base_d = dst_q;
                    state_d       = S_FINISH;
                end else begin
                    state_d = S_PASS_SETUP;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

`ifdef MERGE_PASS_SCHED_PERF_EN
    // Counts cycles with busy high; restarts on an accepted start.
    always_comb begin
        job_cycles_d = job_cycles_q;
        if (start_accept) begin
            job_cycles_d = '0;
        end else if (busy_q) begin
            job_cycles_d = job_cycles_q + 48'd1;
        end
    end
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q         <= S_IDLE;
            src_q           <= '0;
            dst_q           <= '0;
            total_q         <= '0;
            run_q           <= '0;
            off_q           <= '0;
            pass_idx_q      <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            rd_pass_start_q <= 1'b0;
            rd_ctrl_start_q <= 1'b0;
            wr_start_q      <= 1'b0;
            rd_addr_q       <= '0;
            rd_xfer_q       <= '0;
            wr_addr_q       <= '0;
            result_base_q   <= '0;
            rd_seen_q       <= 1'b0;
            wr_seen_q       <= 1'b0;
`ifdef MERGE_PASS_SCHED_PERF_EN
            job_cycles_q    <= '0;
`endif
        end else begin
            state_q         <= state_d;
            src_q           <= src_d;
            dst_q           <= dst_d;
            total_q         <= total_d;
            run_q           <= run_d;
            off_q           <= off_d;
            pass_idx_q      <= pass_idx_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            rd_pass_start_q <= rd_pass_start_d;
            rd_ctrl_start_q <= rd_ctrl_start_d;
            wr_start_q      <= wr_start_d;
            rd_addr_q       <= rd_addr_d;
            rd_xfer_q       <= rd_xfer_d;
            wr_addr_q       <= wr_addr_d;
            result_base_q   <= result_base_d;
            rd_seen_q       <= rd_seen_d;
            wr_seen_q       <= wr_seen_d;
`ifdef MERGE_PASS_SCHED_PERF_EN
            job_cycles_q    <= job_cycles_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass_idx       = pass_idx_q;
    assign rd_pass_start  = rd_pass_start_q;
    assign rd_ctrl_start  = rd_ctrl_start_q;
    assign rd_addr_offset = rd_addr_q;
    assign rd_xfer_size   = rd_xfer_q;
    assign wr_start       = wr_start_q;
    assign wr_addr        = wr_addr_q;
    assign result_base    = result_base_q;
`ifdef MERGE_PASS_SCHED_PERF_EN
    assign job_cycles     = job_cycles_q;
`endif

endmodule
